cordiv_ctrl: RTL
================

# cordiv_ctrl

Sequencing controller for the correlated stochastic divider datapath (the regenerating CORDIV block with `randnum`, `sel`, `dividend`, `divisor`, `quotient` ports). It accepts a binary dividend/divisor pair over a valid/ready handshake, converts both to correlated bitstreams from one shared LFSR, and drives the divider's random-number and select inputs. After a warm-up period it counts quotient ones over a fixed stream length and returns the binary count over a second valid/ready handshake. The divider is instantiated beside this block, not inside it.

## Interface
Parameters:
- `WIDTH`, 8: operand and random-number width; must equal the divider's `randnum` width.
- `LEN`, 256: counted stream length in cycles; power of two, 2..4096.
- `WARMUP`, 16: uncounted cycles before counting; at least 1. They let the divider's regeneration counters settle.
- `SEED`, 8'hA5: nonzero LFSR seed; the value 0 is replaced by 8'h01.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  controller idle and able to accept.
- `in_dividend`  in  WIDTH  binary dividend.
- `in_divisor`  in  WIDTH  binary divisor.
- `dp_randnum`  out  WIDTH  to the divider's `randnum`.
- `dp_sel`  out  1  to the divider's `sel`.
- `dp_dividend`  out  1  dividend bitstream to the divider.
- `dp_divisor`  out  1  divisor bitstream to the divider.
- `dp_quotient`  in  1  quotient bitstream from the divider.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  $clog2(LEN)+1  count of quotient ones, 0..LEN.
- `out_div_zero`  out  1  divisor was 0; `out_result` is forced to LEN.

## Operation
- FSM states (in the package): IDLE, WARM, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid` is high, register both operands, clear the counters, and go to WARM.
  - If the registered divisor is 0, go to DONE instead, with result=LEN and `div_zero`=1.
- WARM:
  - Drive the streams for WARMUP cycles; quotient is ignored.
  - Then go to RUN.
- RUN:
  - Drive the streams for LEN cycles.
  - Add `dp_quotient` to the ones counter in every RUN cycle.
  - Then go to DONE.
- DONE:
  - `out_valid`=1; result and `div_zero` are stable.
  - When `out_ready` is high, go to IDLE.
- Stream generation:
  - Main LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, period 255, never 0. It is zero-extended or truncated to WIDTH to form `rng`, which steps every WARM and RUN cycle.
  - `dp_dividend` = (dividend_reg > rng); `dp_divisor` = (divisor_reg > rng). Both streams share `rng`, so they are correlated as CORDIV requires.
  - `dp_randnum` is a second copy of `rng`, taken from the LFSR rotated by 4 bits, so regeneration is decorrelated from generation.
  - `dp_sel` = bit 0 of a second LFSR with the same polynomial, seeded with ~SEED.
- Outside WARM/RUN: the stream outputs, `dp_sel` and `dp_randnum` are 0, and the LFSRs hold their state. The LFSRs are not reseeded between operations.
- Width rules:
  - The ones counter is $clog2(LEN)+1 bits wide and cannot overflow.
  - The WARM and RUN cycle counters are sized from max(WARMUP, LEN).
- `in_valid` outside IDLE is ignored; `in_ready`=0 there.
- Dividend > divisor gets no special handling; the result saturates toward LEN through the divider itself.

## Timing
- Reset values: state IDLE; `in_ready`=1; `out_valid`=0; `out_result`=0; `out_div_zero`=0; all `dp_*`=0; LFSRs at SEED and ~SEED, with 0 replaced by 8'h01.
- Reset mid-operation aborts immediately. No result is produced and the next accept starts clean.
- Latency: for an accept edge at cycle t, `out_valid` rises at t+1+WARMUP+LEN.
- Divisor-zero latency: `out_valid` rises at t+1.
- Throughput: one operation per WARMUP+LEN+2 cycles at best, since IDLE lasts at least one cycle after DONE.
- `out_result` and `out_div_zero` hold while `out_valid` is high and `out_ready` is low. They clear on the cycle after the handshake.
- Streams are presented combinationally from registered state, in the same cycle as `rng`.

## Structure
- Package `cordiv_ctrl_pkg`:
  - state enum;
  - LFSR tap constant (8'hB8);
  - default seed;
  - the zero-seed substitution function.
- Sub-module `sc_lfsr8`:
  - ports: enable, seed parameter, 8-bit state output;
  - instantiated twice, for `rng` and for `sel`.
- Top level holds the FSM, operand registers, comparators, counters and the handshakes.

## Test plan
- Reset: assert `rst_n`=0 in any state. Required: `in_ready`=1, `out_valid`=0, all `dp_*`=0; the LFSR restarts at SEED, checked by comparing `dp_randnum` sequences across two resets.
- Nominal divide (bench divider model): dividend=64, divisor=128, LEN=256. Required: `out_valid` exactly at t+273; `out_result` in 112..144; `div_zero`=0.
- Divisor zero: divisor=0, dividend=77. Required: `out_valid` at t+1, `out_result`=256, `out_div_zero`=1.
- Backpressure: hold `out_ready`=0 for 50 cycles in DONE, and pulse `in_valid` meanwhile. Required: result stable, `in_ready`=0, no new accept. After `out_ready`, IDLE follows within one cycle.
- Equal operands: dividend=divisor=200. Required: `out_result` >= 240.
- Reset mid-RUN: drop `rst_n` at RUN cycle 100, then issue a new operation. Required: no `out_valid` for the aborted operation, and the new operation's latency is exactly WARMUP+LEN+1.

Source files
------------

// File: rtl/cordiv_ctrl_pkg.sv
// ============================================================================
// Module   : cordiv_ctrl_pkg
// Brief    : Shared types, constants and helpers for the CORDIV sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordiv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Tap mask for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] c_LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] c_DEFAULT_SEED = 8'hA5;

  // An all-zero LFSR would lock up, so zero seeds become 1
  function automatic logic [7:0] fix_seed(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordiv_ctrl_if.sv
// ============================================================================
// Module   : cordiv_ctrl_if
// Brief    : Operand and result valid/ready handshakes of the CORDIV sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cordiv_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int LEN   = 256
);
  localparam int RES_W = $clog2(LEN) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic             out_div_zero;

  modport master (
    output in_valid, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_result, out_div_zero
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_result, out_div_zero
  );

endinterface

`default_nettype wire

// File: rtl/sc_lfsr8.sv
// ============================================================================
// Module   : sc_lfsr8
// Brief    : 8-bit Fibonacci LFSR with enable; steps only while enabled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_lfsr8
  import cordiv_ctrl_pkg::*;
#(
  parameter logic [7:0] SEED = c_DEFAULT_SEED
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       en,
  output logic [7:0]      state
);

  localparam logic [7:0] c_INIT = fix_seed(SEED);

  logic [7:0] r_state;
  logic       w_fb;

  assign w_fb = ^(r_state & c_LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_INIT;
    end else if (en) begin
      r_state <= {r_state[6:0], w_fb};
    end
  end

  assign state = r_state;

endmodule

`default_nettype wire

// File: rtl/cordiv_ctrl.sv
// ============================================================================
// Module   : cordiv_ctrl
// Brief    : Sequencer feeding correlated bitstreams to a CORDIV divider and
//            counting its quotient ones into a binary result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordiv_ctrl
  import cordiv_ctrl_pkg::*;
#(
  parameter int         WIDTH  = 8,
  parameter int         LEN    = 256,
  parameter int         WARMUP = 16,
  parameter logic [7:0] SEED   = c_DEFAULT_SEED
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  cordiv_ctrl_if.slave          bus,
  output logic [WIDTH-1:0]      dp_randnum,
  output logic                  dp_sel,
  output logic                  dp_dividend,
  output logic                  dp_divisor,
  input  wire logic             dp_quotient
);

  localparam int c_RES_W = $clog2(LEN) + 1;
  localparam int c_MAXC  = (WARMUP > LEN) ? WARMUP : LEN;
  localparam int c_CNT_W = (c_MAXC > 1) ? $clog2(c_MAXC) : 1;

  localparam logic [c_CNT_W-1:0] c_WARM_LAST = c_CNT_W'(WARMUP - 1);
  localparam logic [c_CNT_W-1:0] c_RUN_LAST  = c_CNT_W'(LEN - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_RES_W-1:0] c_RES_LEN   = c_RES_W'(LEN);

  state_e             r_state;
  state_e             w_next;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_RES_W-1:0] r_ones;
  logic               r_div_zero;
  logic               w_active;
  logic               w_in_zero;
  logic [7:0]         w_lfsr_rng;
  logic [7:0]         w_lfsr_sel;
  logic [7:0]         w_lfsr_rot;
  logic [WIDTH-1:0]   w_rng;
  logic [WIDTH-1:0]   w_rnd;
  logic               w_unused_sel;

  assign w_in_zero = (bus.in_divisor == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.in_valid) w_next = w_in_zero ? DONE : WARM;
      WARM: if (r_cnt == c_WARM_LAST) w_next = RUN;
      RUN:  if (r_cnt == c_RUN_LAST) w_next = DONE;
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    w_active      = 1'b0;
    case (r_state)
      IDLE:      bus.in_ready  = 1'b1;
      WARM, RUN: w_active      = 1'b1;
      DONE:      bus.out_valid = 1'b1;
      default:   ;
    endcase
  end

  // Operands, phase counter and quotient-ones counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_cnt      <= '0;
      r_ones     <= '0;
      r_div_zero <= 1'b0;
    end else begin
      if (w_active && (w_next == r_state)) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end else begin
        r_cnt <= '0;
      end
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_dividend <= bus.in_dividend;
            r_divisor  <= bus.in_divisor;
            r_ones     <= w_in_zero ? c_RES_LEN : '0;
            r_div_zero <= w_in_zero;
          end
        end
        RUN:  r_ones <= r_ones + c_RES_W'(dp_quotient);
        DONE: begin
          if (bus.out_ready) begin
            r_ones     <= '0;
            r_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_result   = r_ones;
  assign bus.out_div_zero = r_div_zero;

  sc_lfsr8 #(.SEED(SEED)) u_lfsr_rng (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_active),
    .state (w_lfsr_rng)
  );

  sc_lfsr8 #(.SEED(~SEED)) u_lfsr_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_active),
    .state (w_lfsr_sel)
  );

  // Rotated copy decorrelates regeneration from stream generation
  assign w_lfsr_rot = {w_lfsr_rng[3:0], w_lfsr_rng[7:4]};

  if (WIDTH == 8) begin : g_rng_eq
    assign w_rng = w_lfsr_rng;
    assign w_rnd = w_lfsr_rot;
  end else if (WIDTH > 8) begin : g_rng_ext
    assign w_rng = {{(WIDTH-8){1'b0}}, w_lfsr_rng};
    assign w_rnd = {{(WIDTH-8){1'b0}}, w_lfsr_rot};
  end else begin : g_rng_trunc
    assign w_rng = w_lfsr_rng[WIDTH-1:0];
    assign w_rnd = w_lfsr_rot[WIDTH-1:0];
  end

  assign w_unused_sel = ^w_lfsr_sel[7:1];

  assign dp_dividend = w_active & (r_dividend > w_rng);
  assign dp_divisor  = w_active & (r_divisor  > w_rng);
  assign dp_randnum  = w_active ? w_rnd : '0;
  assign dp_sel      = w_active & w_lfsr_sel[0];

endmodule

`default_nettype wire
